// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Brief    : Instruction-fetch stage. Owns the PC, drives instmem address A and
//            loads the IF/ID register. Optional macro FETCH_ALIGN_CHECK_EN adds
//            misaligned-target detection (Fault + HALT).
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'hBFC00000,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = 32'h00000013
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            PCSrc,
    input  logic [DATA_WIDTH-1:0] PCTarget,
    input  logic [DATA_WIDTH-1:0] ALUResult,
    input  logic                  Stall,
    input  logic                  Flush,
    input  logic [DATA_WIDTH-1:0] Instr,
    output logic [DATA_WIDTH-1:0] A,
    output logic [DATA_WIDTH-1:0] Instr_D,
    output logic [DATA_WIDTH-1:0] PC_D,
    output logic [DATA_WIDTH-1:0] PCPlus4_D,
    output logic                  Valid_D,
    output logic                  Fault
);

    localparam logic [DATA_WIDTH-1:0] PC_STEP    = {{(DATA_WIDTH-3){1'b0}}, 3'd4};
    localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = ~{{(DATA_WIDTH-2){1'b0}}, 2'b11};
    localparam logic [DATA_WIDTH-1:0] ZERO       = '0;

`ifdef FETCH_ALIGN_CHECK_EN
    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1
    } state_t;
`endif

    state_t                  state;
    state_t                  state_next;
    logic [DATA_WIDTH-1:0]   pc;
    logic [DATA_WIDTH-1:0]   pc_plus4;
    logic [DATA_WIDTH-1:0]   pc_sel;
    logic [DATA_WIDTH-1:0]   pc_next;
    logic [DATA_WIDTH-1:0]   pc_load_val;
    logic [DATA_WIDTH-1:0]   instr_d;
    logic [DATA_WIDTH-1:0]   pc_d;
    logic [DATA_WIDTH-1:0]   pc_plus4_d;
    logic                    valid_d;
    logic                    misaligned;
    logic                    update_pc;
    logic                    load_seq;
    logic                    squash;
    logic                    fault_set;

    assign pc_plus4 = pc + PC_STEP;

    always_comb begin
        pc_sel = pc_plus4;
        case (PCSrc)
            2'b01:   pc_sel = PCTarget;
            2'b10:   pc_sel = ALUResult;
            default: pc_sel = pc_plus4;
        endcase
    end

`ifdef FETCH_ALIGN_CHECK_EN
    assign pc_next    = pc_sel;
    assign misaligned = |pc_sel[1:0];
`else
    // Without checking, low bits are simply dropped so the PC stays word aligned.
    assign pc_next    = pc_sel & ALIGN_MASK;
    assign misaligned = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= BOOT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        update_pc   = 1'b0;
        load_seq    = 1'b0;
        squash      = 1'b0;
        fault_set   = 1'b0;
        pc_load_val = pc_next;
        case (state)
            BOOT: begin
                // First fetch is always sequential from RESET_PC; redirects are meaningless here.
                if (!Stall) begin
                    update_pc   = 1'b1;
                    load_seq    = 1'b1;
                    pc_load_val = pc_plus4;
                    state_next  = RUN;
                end
            end
            RUN: begin
                if (Flush || !Stall) begin
                    if (misaligned) begin
                        fault_set = 1'b1;
                        squash    = 1'b1;
`ifdef FETCH_ALIGN_CHECK_EN
                        state_next = HALT;
`endif
                    end else begin
                        update_pc = 1'b1;
                        squash    = Flush;
                        load_seq  = !Flush;
                    end
                end
            end
            default: begin
                // HALT: everything frozen until reset.
                state_next = state;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc         <= RESET_PC;
            instr_d    <= NOP_INSTR;
            pc_d       <= ZERO;
            pc_plus4_d <= ZERO;
            valid_d    <= 1'b0;
        end else begin
            if (update_pc) begin
                pc <= pc_load_val;
            end
            if (squash) begin
                instr_d    <= NOP_INSTR;
                pc_d       <= ZERO;
                pc_plus4_d <= ZERO;
                valid_d    <= 1'b0;
            end else if (load_seq) begin
                instr_d    <= Instr;
                pc_d       <= pc;
                pc_plus4_d <= pc_plus4;
                valid_d    <= 1'b1;
            end
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    logic fault_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fault_q <= 1'b0;
        end else if (fault_set) begin
            fault_q <= 1'b1;
        end
    end

    assign Fault = fault_q;
`else
    assign Fault = 1'b0;
`endif

    assign A         = pc;
    assign Instr_D   = instr_d;
    assign PC_D      = pc_d;
    assign PCPlus4_D = pc_plus4_d;
    assign Valid_D   = valid_d;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Brief    : Self-checking bench for fetch_unit: directed scenarios plus random
//            stimulus against a behavioural fetch model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC  = 32'hBFC00000;
    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    logic        clk;
    logic        rst_n;
    logic [1:0]  pc_src;
    logic [31:0] pc_target;
    logic [31:0] alu_result;
    logic        stall;
    logic        flush;
    logic [31:0] instr;
    logic [31:0] a;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pc_plus4_d;
    logic        valid_d;
    logic        fault;

    int errors;
    int checks;
    bit compare_en;

    // behavioural model of the architectural state
    logic [31:0] m_pc, m_instr_d, m_pc_d, m_pc4_d;
    logic        m_valid, m_fault, m_booted, m_halted;

    fetch_unit #(
        .DATA_WIDTH (32),
        .RESET_PC   (RESET_PC),
        .NOP_INSTR  (NOP_INSTR)
    ) dut (
        .clk       (clk),
        .rst       (rst_n),
        .PCSrc     (pc_src),
        .PCTarget  (pc_target),
        .ALUResult (alu_result),
        .Stall     (stall),
        .Flush     (flush),
        .Instr     (instr),
        .A         (a),
        .Instr_D   (instr_d),
        .PC_D      (pc_d),
        .PCPlus4_D (pc_plus4_d),
        .Valid_D   (valid_d),
        .Fault     (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] imem(input logic [31:0] addr);
        if (addr == RESET_PC) return 32'h00500093;
        return {addr[7:0], addr[31:8]} ^ 32'h13579BDF;
    endfunction

    assign instr = imem(a);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = RESET_PC; m_instr_d = NOP_INSTR; m_pc_d = 0; m_pc4_d = 0;
        m_valid = 0; m_fault = 0; m_booted = 0; m_halted = 0;
    endtask

    // One clock edge of the fetch stage, described by its architectural rules.
    task automatic model_step();
        logic [31:0] tgt;
        tgt = (pc_src == 2'b01) ? pc_target : (pc_src == 2'b10) ? alu_result : m_pc + 32'd4;
        if (m_halted) return;
        if (!m_booted) begin
            if (!stall) begin
                m_instr_d = imem(m_pc); m_pc_d = m_pc; m_pc4_d = m_pc + 32'd4;
                m_valid = 1; m_pc = m_pc + 32'd4; m_booted = 1;
            end
            return;
        end
        if (stall && !flush) return;
`ifdef FETCH_ALIGN_CHECK_EN
        if (tgt[1:0] != 2'b00) begin
            m_fault = 1; m_halted = 1;
            m_instr_d = NOP_INSTR; m_pc_d = 0; m_pc4_d = 0; m_valid = 0;
            return;
        end
`endif
        if (flush) begin
            m_instr_d = NOP_INSTR; m_pc_d = 0; m_pc4_d = 0; m_valid = 0;
        end else begin
            m_instr_d = imem(m_pc); m_pc_d = m_pc; m_pc4_d = m_pc + 32'd4; m_valid = 1;
        end
        m_pc = {tgt[31:2], 2'b00};
    endtask

    // Called just after a rising edge: drive inputs, step model, cross the next edge.
    task automatic step(input logic [1:0] src, input logic [31:0] tg, input logic [31:0] alu,
                        input logic st, input logic fl);
        pc_src = src; pc_target = tg; alu_result = alu; stall = st; flush = fl;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        step(2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_A", a, RESET_PC);
        chk("rst_Instr_D", instr_d, NOP_INSTR);
        chk("rst_PC_D", pc_d, 32'h0);
        chk("rst_PCPlus4_D", pc_plus4_d, 32'h0);
        chk("rst_Valid_D", {31'h0, valid_d}, 32'h0);
        chk("rst_Fault", {31'h0, fault}, 32'h0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
    endtask

    always @(negedge clk) begin
        if (compare_en) begin
            chk("cmp_A", a, m_pc);
            chk("cmp_Instr_D", instr_d, m_instr_d);
            chk("cmp_PC_D", pc_d, m_pc_d);
            chk("cmp_PCPlus4_D", pc_plus4_d, m_pc4_d);
            chk("cmp_Valid_D", {31'h0, valid_d}, {31'h0, m_valid});
            chk("cmp_Fault", {31'h0, fault}, {31'h0, m_fault});
        end
    end

    initial begin
        logic [31:0] held_a, held_pcd, held_instr;
        logic [1:0]  rsrc;
        logic [31:0] rt, ra;
        errors = 0; checks = 0; compare_en = 0;
        rst_n = 1'b1;
        pc_src = 0; pc_target = 0; alu_result = 0; stall = 0; flush = 0;
        #3;
        apply_reset();
        compare_en = 1;

        // boot fetch
        idle();
        chk("boot_Instr_D", instr_d, 32'h00500093);
        chk("boot_PC_D", pc_d, RESET_PC);
        chk("boot_Valid_D", {31'h0, valid_d}, 32'h1);
        chk("boot_A", a, RESET_PC + 32'd4);

        // sequential run
        for (int k = 1; k < 4; k++) begin
            idle();
            chk("seq_PC_D", pc_d, RESET_PC + 32'(4 * k));
            chk("seq_PCPlus4_D", pc_plus4_d, RESET_PC + 32'(4 * k + 4));
        end

        // taken branch with flush
        step(2'b01, RESET_PC + 32'h40, 32'h0, 1'b0, 1'b1);
        chk("br_Valid_D", {31'h0, valid_d}, 32'h0);
        chk("br_Instr_D", instr_d, NOP_INSTR);
        chk("br_A", a, RESET_PC + 32'h40);
        idle();
        chk("br_PC_D", pc_d, RESET_PC + 32'h40);

        // stall for three cycles
        held_a = a; held_pcd = pc_d; held_instr = instr_d;
        repeat (3) step(2'b00, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("stall_A", a, held_a);
        chk("stall_PC_D", pc_d, held_pcd);
        chk("stall_Instr_D", instr_d, held_instr);
        idle();
        chk("stall_resume_PC_D", pc_d, held_a);

        // stall and flush together: flush wins
        step(2'b10, 32'h0, 32'h100, 1'b1, 1'b1);
        chk("sf_A", a, 32'h100);
        chk("sf_Valid_D", {31'h0, valid_d}, 32'h0);

        // PC wrap-around
        step(2'b10, 32'h0, 32'hFFFFFFFC, 1'b0, 1'b1);
        idle();
        chk("wrap_A", a, 32'h0);
        chk("wrap_PC_D", pc_d, 32'hFFFFFFFC);
        chk("wrap_PCPlus4_D", pc_plus4_d, 32'h0);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            rsrc = 2'($urandom_range(0, 3));
            rt = $urandom; ra = $urandom;
            if ($urandom_range(0, 31) != 0) begin
                rt[1:0] = 2'b00; ra[1:0] = 2'b00;
            end
            step(rsrc, rt, ra, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
        end

        // mid-run reset, then misaligned jalr
        apply_reset();
        idle();
        step(2'b10, 32'h0, 32'h102, 1'b0, 1'b1);
`ifdef FETCH_ALIGN_CHECK_EN
        chk("mis_Fault", {31'h0, fault}, 32'h1);
        chk("mis_Valid_D", {31'h0, valid_d}, 32'h0);
`else
        chk("mis_A", a, 32'h100);
        chk("mis_Fault", {31'h0, fault}, 32'h0);
`endif
        for (int n = 0; n < 20; n++) begin
            step(2'($urandom_range(0, 3)), $urandom, $urandom,
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
        end

        compare_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
